// File: rtl/scm_pkg.sv
// Shared types and constants for the serial carry-merge stage.
package scm_pkg;

    localparam int SCM_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_carry_merge_if.sv
// Beat-input / result-output bundle of the serial carry-merge stage.
interface serial_carry_merge_if
    import scm_pkg::*;
#(
    parameter int WIDTH = SCM_WIDTH_DEF
);

    // Handshakes: a beat moves when in_valid & in_ready on a rising edge, a result
    // moves when out_valid & out_ready; once raised, out_valid and the result hold
    // until taken, and in_valid may drop at any time (gap).
    logic             start;
    logic             in_valid;
    logic             ha_sum;
    logic             ha_carry;
    logic             in_ready;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             proto_err;

    modport master (
        output start, in_valid, ha_sum, ha_carry, out_ready,
        input  in_ready, sum_out, carry_out, out_valid, busy, proto_err
    );

    modport slave (
        input  start, in_valid, ha_sum, ha_carry, out_ready,
        output in_ready, sum_out, carry_out, out_valid, busy, proto_err
    );

endinterface

// File: rtl/half_add_cell.sv
// Single-bit half adder: XOR gives the sum bit, AND gives the carry bit.
module half_add_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_carry_merge.sv
// Folds a stream of half-adder (sum, carry) bits, LSB first, into a WIDTH-bit
// full-add result by merging each beat with a stored running carry.
module serial_carry_merge
    import scm_pkg::*;
#(
    parameter int WIDTH = SCM_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_carry_merge_if.slave  bus,
    output state_t               dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;

    logic             cell_s;
    logic             cell_c;
    logic             merge_c;
    logic [WIDTH-1:0] shreg_next;

    // Second half adder of the full-add: beat sum against the stored carry.
    half_add_cell u_cell (
        .a (bus.ha_sum),
        .b (carry),
        .s (cell_s),
        .c (cell_c)
    );

    assign merge_c    = bus.ha_carry | cell_c;
    assign shreg_next = {cell_s, shreg[WIDTH-1:1]};
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            carry         <= 1'b0;
            cnt           <= '0;
            shreg         <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.proto_err <= 1'b0;
            bus.sum_out   <= '0;
            bus.carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= SHIFT;
                        carry         <= 1'b0;
                        cnt           <= '0;
                        shreg         <= '0;
                        bus.proto_err <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.in_valid && bus.in_ready) begin
                        shreg <= shreg_next;
                        carry <= merge_c;
                        // Both bits set cannot come from a real half adder.
                        if (bus.ha_sum && bus.ha_carry) begin
                            bus.proto_err <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            cnt           <= '0;
                            state         <= HOLD;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.sum_out   <= shreg_next;
                            bus.carry_out <= merge_c;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_carry_merge.sv
// Directed bench for serial_carry_merge at WIDTH=8 with hand-computed results.
module tb_serial_carry_merge;
    import scm_pkg::*;

    localparam int W = 8;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    int     total = 0;
    int     bad = 0;
    logic [W:0] exp_q[$];

    serial_carry_merge_if #(.WIDTH(W)) bus ();

    serial_carry_merge #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic drive_beat(input logic s, input logic c);
        bus.in_valid = 1'b1;
        bus.ha_sum   = s;
        bus.ha_carry = c;
        tick();
        bus.in_valid = 1'b0;
        bus.ha_sum   = 1'b0;
        bus.ha_carry = 1'b0;
    endtask

    task automatic accept_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (dbg_state !== IDLE) begin
            bad++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        end
        total++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.proto_err, bus.carry_out} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.in_ready, bus.out_valid, bus.busy, bus.proto_err, bus.carry_out});
        end
        total++;
        if (bus.sum_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_sum got=%h exp=00", bus.sum_out);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] va [2] = '{8'h5A, 8'hFF};
        logic [W-1:0] vb [2] = '{8'h3C, 8'h01};
        logic [W:0]   ve [2] = '{9'h096, 9'h100};
        logic [W:0]   exp;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(ve[k]);
            do_start();
            total++;
            if (dbg_state !== SHIFT || bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_enter_shift got=%0d/%b/%b exp=%0d/1/1",
                         dbg_state, bus.in_ready, bus.busy, SHIFT);
            end
            for (int i = 0; i < W; i++) begin
                if (i == W - 1) begin
                    total++;
                    if (bus.out_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid);
                    end
                end
                drive_beat(va[k][i] ^ vb[k][i], va[k][i] & vb[k][i]);
            end
            exp = exp_q.pop_front();
            total++;
            if (bus.out_valid !== 1'b1 || dbg_state !== HOLD || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL basic_hold got=%b/%0d/%b exp=1/%0d/0",
                         bus.out_valid, dbg_state, bus.in_ready, HOLD);
            end
            total++;
            if ({bus.carry_out, bus.sum_out} !== exp) begin
                bad++;
                $display("FAIL basic_result got=%h exp=%h", {bus.carry_out, bus.sum_out}, exp);
            end
            total++;
            if (bus.proto_err !== 1'b0) begin
                bad++;
                $display("FAIL basic_proto got=%b exp=0", bus.proto_err);
            end
            accept_result();
            total++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || dbg_state !== IDLE) begin
                bad++;
                $display("FAIL basic_release got=%b/%b/%0d exp=0/0/%0d",
                         bus.out_valid, bus.busy, dbg_state, IDLE);
            end
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] a = 8'h81;
        logic [W-1:0] b = 8'h81;
        logic [W:0]   exp;
        exp_q.push_back(9'h102);
        do_start();
        for (int i = 0; i < W; i++) begin
            drive_beat(a[i] ^ b[i], a[i] & b[i]);
            if (i == 1 || i == 4) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    total++;
                    if (dbg_state !== SHIFT || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                        bad++;
                        $display("FAIL gap_hold got=%0d/%b/%b exp=%0d/0/1",
                                 dbg_state, bus.out_valid, bus.in_ready, SHIFT);
                    end
                end
            end
        end
        exp = exp_q.pop_front();
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL gap_valid got=%b exp=1", bus.out_valid);
        end
        total++;
        if ({bus.carry_out, bus.sum_out} !== exp) begin
            bad++;
            $display("FAIL gap_result got=%h exp=%h", {bus.carry_out, bus.sum_out}, exp);
        end
        accept_result();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a = 8'h12;
        logic [W-1:0] b = 8'h34;
        do_start();
        for (int i = 0; i < W; i++) drive_beat(a[i] ^ b[i], a[i] & b[i]);
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 1);
            tick();
            total++;
            if (dbg_state !== HOLD || bus.out_valid !== 1'b1 || bus.sum_out !== 8'h46
                || bus.carry_out !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall got=%0d/%b/%h/%b exp=%0d/1/46/0",
                         dbg_state, bus.out_valid, bus.sum_out, bus.carry_out, HOLD);
            end
        end
        bus.start = 1'b0;
        accept_result();
        total++;
        if (dbg_state !== IDLE || bus.out_valid !== 1'b0 || bus.sum_out !== 8'h46) begin
            bad++;
            $display("FAIL bp_release got=%0d/%b/%h exp=%0d/0/46",
                     dbg_state, bus.out_valid, bus.sum_out, IDLE);
        end
        tick();
        total++;
        if (dbg_state !== IDLE) begin
            bad++;
            $display("FAIL bp_no_queue got=%0d exp=%0d", dbg_state, IDLE);
        end
        do_start();
        for (int i = 0; i < W; i++) drive_beat(i == 0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || {bus.carry_out, bus.sum_out} !== 9'h001) begin
            bad++;
            $display("FAIL bp_next_op got=%b/%h exp=1/001",
                     bus.out_valid, {bus.carry_out, bus.sum_out});
        end
        accept_result();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] a = 8'h10;
        logic [W-1:0] b = 8'h20;
        do_start();
        drive_beat(1'b1, 1'b0);
        drive_beat(1'b1, 1'b1);
        drive_beat(1'b0, 1'b1);
        drive_beat(1'b1, 1'b0);
        total++;
        if (bus.proto_err !== 1'b1 || dbg_state !== SHIFT) begin
            bad++;
            $display("FAIL rstmid_pre got=%b/%0d exp=1/%0d", bus.proto_err, dbg_state, SHIFT);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (dbg_state !== IDLE || {bus.in_ready, bus.out_valid, bus.busy, bus.proto_err,
                                   bus.carry_out} !== 5'b0 || bus.sum_out !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_clear got=%0d/%b/%h exp=%0d/00000/00", dbg_state,
                     {bus.in_ready, bus.out_valid, bus.busy, bus.proto_err, bus.carry_out},
                     bus.sum_out, IDLE);
        end
        do_start();
        for (int i = 0; i < W; i++) drive_beat(a[i] ^ b[i], a[i] & b[i]);
        total++;
        if (bus.out_valid !== 1'b1 || {bus.carry_out, bus.sum_out} !== 9'h030) begin
            bad++;
            $display("FAIL rstmid_fresh got=%b/%h exp=1/030",
                     bus.out_valid, {bus.carry_out, bus.sum_out});
        end
        accept_result();
    endtask

    task automatic test_proto_err();
        do_start();
        drive_beat(1'b0, 1'b0);
        drive_beat(1'b0, 1'b0);
        total++;
        if (bus.proto_err !== 1'b0) begin
            bad++;
            $display("FAIL proto_before got=%b exp=0", bus.proto_err);
        end
        drive_beat(1'b1, 1'b1);
        total++;
        if (bus.proto_err !== 1'b1) begin
            bad++;
            $display("FAIL proto_set got=%b exp=1", bus.proto_err);
        end
        for (int i = 3; i < W; i++) drive_beat(1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (bus.proto_err !== 1'b1 || bus.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL proto_hold got=%b/%b exp=1/1", bus.proto_err, bus.out_valid);
            end
            tick();
        end
        total++;
        if ({bus.carry_out, bus.sum_out} !== 9'h00C) begin
            bad++;
            $display("FAIL proto_result got=%h exp=00c", {bus.carry_out, bus.sum_out});
        end
        accept_result();
        total++;
        if (bus.proto_err !== 1'b1 || dbg_state !== IDLE) begin
            bad++;
            $display("FAIL proto_idle got=%b/%0d exp=1/%0d", bus.proto_err, dbg_state, IDLE);
        end
        do_start();
        total++;
        if (bus.proto_err !== 1'b0) begin
            bad++;
            $display("FAIL proto_clear got=%b exp=0", bus.proto_err);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ha_sum    = 1'b0;
        bus.ha_carry  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_proto_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
